// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: instruction-fetch PC sequencer.
// Issues one memory request at a time and delivers the returned words
// together with their PC. Branches redirect the fetch stream. If a
// request is still outstanding when a branch arrives, that request is
// finished and its data is thrown away.
// Optional build macro MISALIGN_TRAP_EN: when it is defined, a branch to
// a target that is not word aligned sets the sticky misaligned flag and
// halts fetching until reset. When it is not defined, the low two target
// bits are cleared and misaligned is tied low.
//
// state | meaning
// IDLE  | no request; leaves after one cycle (stays while trapped)
// FETCH | request at fetchAddr outstanding; delivers data on ack
// FLUSH | request outstanding whose data will be discarded; then
//       | jumps to the latched branch target
// HOLD  | delivered instruction frozen while downstream stalls
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   input  logic        stall,
   output logic        fetchReq,
   output logic [31:0] fetchAddr,
   input  logic        fetchAck,
   input  logic [31:0] fetchData,
   output logic [31:0] instr,
   output logic [31:0] instrPC,
   output logic        instrValid,
   output logic        misaligned
);

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HOLD} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_valid, w_valid_nxt;
   logic [31:0] r_target, w_target_nxt;
   logic [31:0] w_tgt;
   logic        w_bad;
   logic        w_halt;

`ifdef MISALIGN_TRAP_EN
   logic r_mis;
   logic w_mis_nxt;

   assign w_tgt      = branchTarget;
   assign w_bad      = branchTaken && (branchTarget[1:0] != 2'b00);
   assign w_halt     = r_mis;
   assign w_mis_nxt  = r_mis | w_bad;
   assign misaligned = r_mis;

   // sticky trap flag, cleared only by reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_mis <= 1'b0;
      else        r_mis <= w_mis_nxt;
   end
`else
   // the target is forced to a word boundary before it is used
   assign w_tgt      = branchTarget & 32'hFFFF_FFFC;
   assign w_bad      = 1'b0;
   assign w_halt     = 1'b0;
   assign misaligned = 1'b0;
`endif

   assign fetchAddr  = r_addr;
   assign instr      = r_instr;
   assign instrPC    = r_pc;
   assign instrValid = r_valid;

   // state and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_addr   <= RESET_PC;
         r_instr  <= 32'h0;
         r_pc     <= 32'h0;
         r_valid  <= 1'b0;
         r_target <= 32'h0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_instr  <= w_instr_nxt;
         r_pc     <= w_pc_nxt;
         r_valid  <= w_valid_nxt;
         r_target <= w_target_nxt;
      end
   end

   // next-state and request logic
   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      w_instr_nxt  = r_instr;
      w_pc_nxt     = r_pc;
      w_valid_nxt  = r_valid;
      w_target_nxt = r_target;
      fetchReq     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_halt) begin
               w_state_nxt = FETCH;
               if (branchTaken) begin
                  w_addr_nxt  = w_tgt;
                  w_valid_nxt = 1'b0;
               end
            end
         end
         FETCH: begin
            fetchReq    = 1'b1;
            w_valid_nxt = 1'b0;
            if (fetchAck && branchTaken) begin
               w_addr_nxt = w_tgt;
            end else if (fetchAck) begin
               w_instr_nxt = fetchData;
               w_pc_nxt    = r_addr;
               w_valid_nxt = 1'b1;
               w_addr_nxt  = r_addr + 32'd4;
               if (stall) w_state_nxt = HOLD;
            end else if (branchTaken) begin
               w_target_nxt = w_tgt;
               w_state_nxt  = FLUSH;
            end
         end
         FLUSH: begin
            fetchReq    = 1'b1;
            w_valid_nxt = 1'b0;
            if (branchTaken) w_target_nxt = w_tgt;
            if (fetchAck) begin
               // a branch arriving with the ack is the newest one, so it wins
               w_addr_nxt  = branchTaken ? w_tgt : r_target;
               w_state_nxt = FETCH;
            end
         end
         HOLD: begin
            if (branchTaken) begin
               w_addr_nxt  = w_tgt;
               w_valid_nxt = 1'b0;
            end
            if (!stall) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = FETCH;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // misaligned trap: drop the branch and park in IDLE
      if (w_bad) begin
         w_state_nxt  = IDLE;
         w_valid_nxt  = 1'b0;
         w_addr_nxt   = r_addr;
         w_target_nxt = r_target;
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: a directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_pc_fetch_sequencer;

`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset, branchTaken, stall, fetchAck;
   logic [31:0] branchTarget, fetchData;
   logic        fetchReq, instrValid, misaligned;
   logic [31:0] fetchAddr, instr, instrPC;

   logic        reset2, ack2, br2, stall2;
   logic [31:0] tgt2, data2;
   logic        req2, valid2, mis2;
   logic [31:0] addr2, instr2, pc2;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   pc_fetch_sequencer dut (
      .clock(clock), .reset(reset), .branchTaken(branchTaken),
      .branchTarget(branchTarget), .stall(stall), .fetchReq(fetchReq),
      .fetchAddr(fetchAddr), .fetchAck(fetchAck), .fetchData(fetchData),
      .instr(instr), .instrPC(instrPC), .instrValid(instrValid),
      .misaligned(misaligned)
   );

   pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clock(clock), .reset(reset2), .branchTaken(br2),
      .branchTarget(tgt2), .stall(stall2), .fetchReq(req2),
      .fetchAddr(addr2), .fetchAck(ack2), .fetchData(data2),
      .instr(instr2), .instrPC(pc2), .instrValid(valid2),
      .misaligned(mis2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      branchTaken = 1'b0; branchTarget = 32'h0; stall = 1'b0;
      fetchAck = 1'b0; fetchData = 32'h0;
   endtask

   // reset is held over two edges; the reset values are checked while it is low
   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      @(negedge clock);
      chk("rst_req", fetchReq, 0);
      chk("rst_addr", fetchAddr, 32'h0);
      chk("rst_valid", instrValid, 0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instrPC, 32'h0);
      chk("rst_mis", misaligned, 0);
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic step();
      @(posedge clock); #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        br;
      logic [31:0] tgt;
      logic        stl;
      logic        ack;
      logic [31:0] data;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] ins;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[$];

   function automatic void addv(input logic br, input logic [31:0] tgt, input logic stl,
                                input logic ack, input logic [31:0] data, input logic req,
                                input logic [31:0] addr, input logic valid,
                                input logic [31:0] ins, input logic [31:0] pc);
      vec_t v;
      v.br = br; v.tgt = tgt; v.stl = stl; v.ack = ack; v.data = data;
      v.req = req; v.addr = addr; v.valid = valid; v.ins = ins; v.pc = pc;
      vecs.push_back(v);
   endfunction

   // ---------------- reference model ----------------
   // Sequencer described by its activity: started / holding / flushing / halted.
   bit          m_started, m_hold, m_flush, m_halt;
   logic [31:0] m_addr, m_instr, m_pc, m_pend;
   logic        m_valid, m_mis;

   function automatic void model_reset();
      m_started = 0; m_hold = 0; m_flush = 0; m_halt = 0;
      m_addr = 32'h0; m_instr = 32'h0; m_pc = 32'h0; m_pend = 32'h0;
      m_valid = 0; m_mis = 0;
   endfunction

   function automatic logic model_req();
      return m_started && !m_hold && !m_halt;
   endfunction

   function automatic void model_step(input logic br, input logic [31:0] tg_raw,
                                      input logic stl, input logic ack, input logic [31:0] data);
      logic [31:0] t;
      t = TRAP ? tg_raw : {tg_raw[31:2], 2'b00};
      if (m_halt) begin
      end else if (TRAP && br && (tg_raw[1:0] != 2'b00)) begin
         m_halt = 1; m_mis = 1; m_valid = 0; m_started = 0;
      end else if (!m_started) begin
         if (br) begin m_addr = t; m_valid = 0; end
         m_started = 1;
      end else if (m_hold) begin
         if (br) begin m_addr = t; m_valid = 0; end
         if (!stl) begin m_valid = 0; m_hold = 0; end
      end else if (m_flush) begin
         m_valid = 0;
         if (br) m_pend = t;
         if (ack) begin m_addr = m_pend; m_flush = 0; end
      end else begin
         m_valid = 0;
         if (ack && br) m_addr = t;
         else if (ack) begin
            m_instr = data; m_pc = m_addr; m_valid = 1;
            m_addr = m_addr + 32'd4;
            if (stl) m_hold = 1;
         end else if (br) begin
            m_pend = t; m_flush = 1;
         end
      end
   endfunction

   logic [31:0] got[3];
   int          ngot;
   bit          nxt_ack;
   int          halt_cnt;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset2 = 1'b0; ack2 = 1'b0; br2 = 1'b0; stall2 = 1'b0; tgt2 = 32'h0; data2 = 32'h0;
      idle_inputs();
      reset = 1'b0;

      // sequential fetch, stall hold, ignored ack in HOLD, branch during
      // an outstanding request, branch on the ack cycle
      addv(0,0,0,0,0,            0,32'h0,  0,0,0);
      addv(0,0,0,0,0,            1,32'h0,  0,0,0);
      addv(0,0,0,1,32'hA0,       1,32'h0,  0,0,0);
      addv(0,0,0,0,0,            1,32'h4,  1,32'hA0,32'h0);
      addv(0,0,0,1,32'hA4,       1,32'h4,  0,0,0);
      addv(0,0,0,0,0,            1,32'h8,  1,32'hA4,32'h4);
      addv(0,0,1,1,32'hA8,       1,32'h8,  0,0,0);
      addv(0,0,1,0,0,            0,32'hC,  1,32'hA8,32'h8);
      addv(0,0,1,1,32'hBAD,      0,32'hC,  1,32'hA8,32'h8);
      addv(0,0,1,0,0,            0,32'hC,  1,32'hA8,32'h8);
      addv(0,0,1,0,0,            0,32'hC,  1,32'hA8,32'h8);
      addv(0,0,0,0,0,            0,32'hC,  1,32'hA8,32'h8);
      addv(0,0,0,0,0,            1,32'hC,  0,0,0);
      addv(0,0,0,1,32'hAC,       1,32'hC,  0,0,0);
      addv(0,0,0,0,0,            1,32'h10, 1,32'hAC,32'hC);
      addv(1,32'h100,0,0,0,      1,32'h10, 0,0,0);
      addv(0,0,0,0,0,            1,32'h10, 0,0,0);
      addv(0,0,0,0,0,            1,32'h10, 0,0,0);
      addv(0,0,0,1,32'hB0,       1,32'h10, 0,0,0);
      addv(0,0,0,0,0,            1,32'h100,0,0,0);
      addv(0,0,0,1,32'h1A0,      1,32'h100,0,0,0);
      addv(0,0,0,0,0,            1,32'h104,1,32'h1A0,32'h100);
      addv(1,32'h200,0,1,32'h1A4,1,32'h104,0,0,0);
      addv(0,0,0,0,0,            1,32'h200,0,0,0);
      addv(0,0,0,1,32'h2A0,      1,32'h200,0,0,0);
      addv(0,0,0,0,0,            1,32'h204,1,32'h2A0,32'h200);

      do_reset();
      foreach (vecs[i]) begin
         branchTaken = vecs[i].br; branchTarget = vecs[i].tgt; stall = vecs[i].stl;
         fetchAck = vecs[i].ack; fetchData = vecs[i].data;
         @(negedge clock);
         chk($sformatf("vec%0d_req", i), fetchReq, vecs[i].req);
         chk($sformatf("vec%0d_addr", i), fetchAddr, vecs[i].addr);
         chk($sformatf("vec%0d_valid", i), instrValid, vecs[i].valid);
         chk($sformatf("vec%0d_mis", i), misaligned, 0);
         if (vecs[i].valid) begin
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].ins);
            chk($sformatf("vec%0d_pc", i), instrPC, vecs[i].pc);
         end
         step();
      end

      // misaligned branch target 0x102 while a request to 0 is outstanding
      do_reset();
      step();
      branchTaken = 1'b1; branchTarget = 32'h102;
      step();
      branchTaken = 1'b0;
      fetchAck = 1'b1; fetchData = 32'h1234;
      step();
      fetchAck = 1'b0;
      if (TRAP) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("trap_mis", misaligned, 1);
            chk("trap_req", fetchReq, 0);
            step();
         end
      end else begin
         @(negedge clock);
         chk("align_req", fetchReq, 1);
         chk("align_addr", fetchAddr, 32'h100);
         chk("align_valid", instrValid, 0);
         chk("align_mis", misaligned, 0);
         step();
      end

      // asynchronous reset mid-request after a delivery, then a late ack in IDLE
      do_reset();
      step();
      fetchAck = 1'b1; fetchData = 32'h55;
      step();
      fetchAck = 1'b0;
      @(negedge clock);
      chk("pre_rst_valid", instrValid, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_req", fetchReq, 0);
      chk("async_addr", fetchAddr, 32'h0);
      chk("async_valid", instrValid, 0);
      chk("async_instr", instr, 32'h0);
      chk("async_pc", instrPC, 32'h0);
      fetchAck = 1'b1; fetchData = 32'hDEAD;
      step();
      reset = 1'b1;
      @(negedge clock);
      chk("late_ack_req", fetchReq, 0);
      step();
      fetchAck = 1'b0;
      @(negedge clock);
      chk("late_ack_req2", fetchReq, 1);
      chk("late_ack_addr", fetchAddr, 32'h0);
      chk("late_ack_valid", instrValid, 0);
      step();

      // address wrap with RESET_PC = FFFF_FFF8, memory acks one cycle after a request
      reset2 = 1'b1;
      ngot = 0;
      for (int c = 0; c < 30 && ngot < 3; c++) begin
         @(negedge clock);
         if (req2 && ack2) begin
            got[ngot] = addr2;
            ngot++;
         end
         nxt_ack = req2 && !ack2;
         data2 = addr2 + 32'hA0;
         @(posedge clock); #1;
         ack2 = nxt_ack;
      end
      ack2 = 1'b0;
      chk("wrap_count", ngot, 3);
      if (ngot == 3) begin
         chk("wrap_addr0", got[0], 32'hFFFF_FFF8);
         chk("wrap_addr1", got[1], 32'hFFFF_FFFC);
         chk("wrap_addr2", got[2], 32'h0000_0000);
      end

      // randomized run against the reference model
      do_reset();
      model_reset();
      halt_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         branchTaken  = ($urandom_range(0, 9) == 0);
         branchTarget = $urandom;
         if (TRAP && $urandom_range(0, 15) != 0) branchTarget[1:0] = 2'b00;
         stall     = ($urandom_range(0, 3) == 0);
         fetchAck  = ($urandom_range(0, 2) == 0);
         fetchData = $urandom;
         @(negedge clock);
         chk("rand_req", fetchReq, model_req());
         chk("rand_addr", fetchAddr, m_addr);
         chk("rand_valid", instrValid, m_valid);
         chk("rand_mis", misaligned, m_mis);
         if (m_valid) begin
            chk("rand_instr", instr, m_instr);
            chk("rand_pc", instrPC, m_pc);
         end
         @(posedge clock);
         model_step(branchTaken, branchTarget, stall, fetchAck, fetchData);
         #1;
         halt_cnt = m_halt ? halt_cnt + 1 : 0;
         if (halt_cnt > 4) begin
            do_reset();
            model_reset();
            halt_cnt = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port branchTaken  input  1  one-cycle pulse: redirect fetch to branchTarget.
REQ-005 SHALL have port branchTarget  input  32  PC+immediate branch target, sampled when branchTaken=1.
REQ-006 SHALL have port stall  input  1  downstream cannot accept an instruction.
REQ-007 SHALL have port fetchReq  output  1  instruction memory request.
REQ-008 SHALL have port fetchAddr  output  32  request address.
REQ-009 SHALL have port fetchAck  input  1  memory response valid; completes the request.
REQ-010 SHALL have port fetchData  input  32  instruction word, valid with fetchAck.
REQ-011 SHALL have port instr  output  32  delivered instruction.
REQ-012 SHALL have port instrPC  output  32  PC of delivered instruction.
REQ-013 SHALL have port instrValid  output  1  instr/instrPC valid.
REQ-014 SHALL have port misaligned  output  1  sticky misaligned-target flag (MISALIGN_TRAP_EN only; tied 0 otherwise).

Function
REQ-015 SHALL implement states IDLE, FETCH, FLUSH, HOLD.
REQ-016 IDLE: fetchReq=0; next cycle -> FETCH with fetchAddr=RESET_PC.
REQ-017 FETCH: fetchReq=1, fetchAddr held stable until fetchAck=1 (no address change mid-request).
REQ-018 FETCH with fetchAck, no branch: instr<=fetchData, instrPC<=fetchAddr, instrValid<=1, fetchAddr<=fetchAddr+4 (mod 2^32, wraps FFFF_FFFC->0000_0000).
REQ-019 After delivery, stall=0: remain FETCH, new request next cycle (max one instruction per 2 cycles with 1-cycle ack).
REQ-020 After delivery, stall=1: go HOLD, fetchReq=0, instr/instrPC/instrValid frozen until stall=0, then instrValid<=0 and -> FETCH.
REQ-021 instrValid SHALL drop to 0 the cycle after delivery when stall=0.
REQ-022 branchTaken in FETCH without fetchAck: latch target, -> FLUSH; request held until ack.
REQ-023 FLUSH: on fetchAck discard fetchData (instrValid stays 0), fetchAddr<=latched target, -> FETCH.
REQ-024 branchTaken same cycle as fetchAck: discard fetchData, fetchAddr<=branchTarget, stay FETCH.
REQ-025 branchTaken in FLUSH: overwrite latched target (last branch wins).
REQ-026 branchTaken in HOLD or IDLE: fetchAddr<=branchTarget; instrValid<=0; state transition unchanged.
REQ-027 fetchAck outside FETCH/FLUSH SHALL be ignored.

Reset
REQ-028 reset=0 SHALL immediately force: state IDLE, fetchReq=0, fetchAddr=RESET_PC, instr=0, instrPC=0, instrValid=0, misaligned=0, latched target=0.
REQ-029 Reset mid-request SHALL abandon the request; a late fetchAck after release is ignored (IDLE).

Configuration
REQ-030 Macro MISALIGN_TRAP_EN defined: branchTaken with branchTarget[1:0]!=0 sets misaligned=1, target not applied, sequencer -> IDLE-like halt (fetchReq=0) until reset.
REQ-031 Macro MISALIGN_TRAP_EN undefined: branchTarget[1:0] forced to 00 before use; misaligned tied 0.

Verification
REQ-032 Release reset, fetchAck 1 cycle after each fetchReq, data=A0+addr -> instrPC 0,4,8,C with matching instr, pulses one cycle.
REQ-033 stall=1 for 5 cycles at delivery of PC 8 -> instr/instrPC=8 held, fetchReq=0 throughout, next request addr C.
REQ-034 branchTaken, target 0x100, while request to 0x10 awaits ack (ack 3 cycles later) -> 0x10 data discarded, next fetchAddr 0x100, instrPC 0x100.
REQ-035 branchTaken target 0x200 same cycle as fetchAck -> data dropped, next fetchAddr 0x200.
REQ-036 RESET_PC=FFFF_FFF8 -> fetchAddr FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 MISALIGN_TRAP_EN defined, branch target 0x102 -> misaligned=1, fetchReq=0 until reset; undefined -> fetch from 0x100.
